calc_top_module: RTL and testbench
==================================

Name: calc_top_module

Overview:
- Single-cycle-latency integer scientific calculator with 4-digit seven-segment output.
- An operation is selected by op_code on 10-bit unsigned operands. The result is registered and shown as four decimal digits on seg1..seg4.
- Top level of the calculator; seg outputs drive the board's display pins directly.

Parameters:
- RES_W, 14, width of internal result register (holds 0..9999).
- MAX_DISP, 9999, largest displayable result; anything larger is an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- num  in  10  factorial operand.
- a  in  10  general operand A.
- b  in  10  general operand B.
- n  in  10  nCr/nPr set size.
- r  in  10  nCr/nPr selection size.
- num_sqrt  in  10  square-root operand.
- op_code  in  4  operation select.
- seg1  out  7  thousands digit, active-low, bit6=g .. bit0=a.
- seg2  out  7  hundreds digit, same encoding.
- seg3  out  7  tens digit, same encoding.
- seg4  out  7  units digit, same encoding.

Behaviour:
- Internal registers:
  - res [13:0]: observable by hierarchical name res.
  - err: 1 bit.
- Reset (rst_n=0, async):
  - res=0, err=0.
  - seg1..seg4 = digit 0 (7'b1000000).
- Each rising clk:
  - res/err load the value computed combinationally from the current inputs and op_code.
  - Segments are registered in the same edge, so latency = 1 clock from input change to res and seg.
- No handshake. Inputs are sampled every cycle; the result tracks the inputs continuously.
- Op codes (all unsigned, integer, floor semantics):
  - 0: num! (0!=1). num>7 -> err.
  - 1: a+b.
  - 2: a-b. a<b -> err.
  - 3: nCr. r>n -> err. r=0 or r=n -> 1.
  - 4: a/b quotient. b=0 -> err.
  - 5: a%b. b=0 -> err.
  - 6: floor(log2(a)). a=0 -> err.
  - 7: a*b.
  - 8: nPr = n!/(n-r)!. r>n -> err. r=0 -> 1.
  - 9: a^b. a^0=1, including 0^0=1.
  - 10: floor(sqrt(num_sqrt)).
  - 11-15: err.
- Overflow: any mathematically exact result >9999 sets err.
  - Intermediate products must be computed wide enough, or saturated, so that overflow is never masked by wrap-around.
  - Applies to power, multiply, nCr, nPr and factorial.
- On err:
  - res = 0.
  - All four segments display dash (7'b0111111, only g lit).
- On no error:
  - res is converted to 4 BCD digits; leading zeros are displayed, not blanked.
  - Digit patterns, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset asserted mid-operation clears res, err and segs immediately. Computation resumes on the first clock after release.

Decomposition:
- Package calc_pkg holds:
  - op_code localparams: OP_FACT, OP_ADD, OP_SUB, OP_NCR, OP_DIVQ, OP_DIVR, OP_LOG2, OP_MUL, OP_NPR, OP_POW, OP_SQRT.
  - MAX_DISP.
  - Seven-segment digit and dash constants.
- Sub-module seg7_decoder: 4-bit BCD digit plus err in, 7-bit pattern out. Instantiated four times.
- Binary-to-BCD conversion (double-dabble or div/mod by 10) stays in the top.

Test Plan:
- Reset, then release -> res=0, all segs 7'b1000000. Then num=5, op=0 -> after 1 clk res=120, segs 0,1,2,0.
- a=10,b=5 op=1 -> res=15. a=15,b=5 op=2 -> res=10. a=3,b=4 op=5 -> res=3.
- n=5,r=2 op=3 -> res=10. Same inputs op=8 -> res=20.
- a=20,b=4 op=4 -> res=5. a=20,b=3 op=5 -> res=2. a=16 op=6 -> res=4. a=3,b=4 op=7 -> res=12.
- a=2,b=3 op=9 -> res=8. num_sqrt=16 op=10 -> res=4. num_sqrt=17 op=10 -> res=4.
- Errors -> err=1, res=0, all segs 7'b0111111:
  - b=0 op=4.
  - a=5,b=9 op=2.
  - num=8 op=0.
  - a=100,b=100 op=7.
  - op=15.
  - Also assert rst_n mid-stream: segs return to "0000" without waiting for a clock.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the integer calculator.
//   - op_code encodings (OP_*)
//   - result width and largest displayable value
//   - active-low seven-segment patterns (bit6=g .. bit0=a)
//   - factorial lookup for the only operands that cannot overflow (0..7)
package calc_pkg;

  localparam int          RES_W    = 14;
  localparam int unsigned MAX_DISP = 9999;

  localparam logic [3:0] OP_FACT = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NCR  = 4'd3;
  localparam logic [3:0] OP_DIVQ = 4'd4;
  localparam logic [3:0] OP_DIVR = 4'd5;
  localparam logic [3:0] OP_LOG2 = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_NPR  = 4'd8;
  localparam logic [3:0] OP_POW  = 4'd9;
  localparam logic [3:0] OP_SQRT = 4'd10;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [31:0] fact_lut(input logic [2:0] x);
    logic [31:0] f;
    case (x)
      3'd0:    f = 32'd1;
      3'd1:    f = 32'd1;
      3'd2:    f = 32'd2;
      3'd3:    f = 32'd6;
      3'd4:    f = 32'd24;
      3'd5:    f = 32'd120;
      3'd6:    f = 32'd720;
      default: f = 32'd5040;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/calc_seg7_decoder.sv
// seg7_decoder: one BCD digit to an active-low seven-segment pattern.
//   digit_i [3:0] : BCD digit 0..9
//   err_i         : force the dash pattern
//   seg_o   [6:0] : gfedcba, active-low
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       err_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (!err_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/calc_top_module.sv
// calc_top_module: single-cycle integer calculator with 4-digit display.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   num                 : factorial operand
//   a, b                : general operands
//   n, r                : nCr / nPr set and selection sizes
//   num_sqrt            : square-root operand
//   op_code             : operation select (calc_pkg OP_*)
//   seg1..seg4          : thousands..units digit, active-low gfedcba
// The result and error flag are registered every edge; the display is a
// pure decode of those registers, so it changes on the same edge and can
// never disagree with res.
module calc_top_module
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] num,
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic [9:0] n,
  input  logic [9:0] r,
  input  logic [9:0] num_sqrt,
  input  logic [3:0] op_code,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4
);

  logic [RES_W-1:0] res, res_d;
  logic             err, err_d;

  logic [31:0] val;   // exact result, or any value > MAX_DISP on overflow
  logic [31:0] acc;
  logic        bad;   // domain error (not overflow)
  logic        sat;   // running product already past MAX_DISP
  logic [9:0]  k;

  always_comb begin
    val = '0;
    acc = 32'd1;
    bad = 1'b0;
    sat = 1'b0;
    k   = '0;
    case (op_code)
      OP_FACT: if (num > 10'd7) bad = 1'b1;
               else val = fact_lut(num[2:0]);
      OP_ADD:  val = 32'(a) + 32'(b);
      OP_SUB:  if (a < b) bad = 1'b1;
               else val = 32'(a - b);
      OP_NCR: begin
        if (r > n) bad = 1'b1;
        else begin
          // Use the smaller of r, n-r. With k >= 8 we have n >= 16, so the
          // result is at least C(16,8) = 12870 and always overflows; that
          // bounds the loop at 7 steps. Each step is C(m,i) = C(m-1,i-1)*m/i,
          // exact and non-decreasing, so stopping once past MAX_DISP is safe.
          k = (r > n - r) ? n - r : r;
          if (k > 10'd7) bad = 1'b1;
          else begin
            for (int i = 1; i <= 7; i++)
              if (32'(i) <= 32'(k) && !sat) begin
                acc = (acc * (32'(n) - 32'(k) + 32'(i))) / 32'(i);
                if (acc > 32'(MAX_DISP)) sat = 1'b1;
              end
            val = acc;
          end
        end
      end
      OP_DIVQ: if (b == '0) bad = 1'b1;
               else val = 32'(a / b);
      OP_DIVR: if (b == '0) bad = 1'b1;
               else val = 32'(a % b);
      OP_LOG2: begin
        bad = (a == '0);
        for (int i = 0; i < 10; i++)
          if (a[i]) val = 32'(i);
      end
      OP_MUL:  val = 32'(a) * 32'(b);
      OP_NPR: begin
        // r >= 8 implies nPr >= 8! = 40320, so at most 7 factors matter.
        if (r > n || r > 10'd7) bad = 1'b1;
        else begin
          for (int i = 0; i < 7; i++)
            if (32'(i) < 32'(r) && !sat) begin
              acc = acc * (32'(n) - 32'(i));
              if (acc > 32'(MAX_DISP)) sat = 1'b1;
            end
          val = acc;
        end
      end
      OP_POW: begin
        // a>=2 with b>=14 is at least 16384; otherwise at most 13 factors.
        if (b == '0)           val = 32'd1;
        else if (a <= 10'd1)   val = 32'(a);
        else if (b > 10'd13)   bad = 1'b1;
        else begin
          for (int i = 0; i < 13; i++)
            if (32'(i) < 32'(b) && !sat) begin
              acc = acc * 32'(a);
              if (acc > 32'(MAX_DISP)) sat = 1'b1;
            end
          val = acc;
        end
      end
      OP_SQRT: begin
        for (int i = 0; i < 32; i++)
          if (32'(i * i) <= 32'(num_sqrt)) val = 32'(i);
      end
      default: bad = 1'b1;
    endcase
  end

  assign err_d = bad || (val > 32'(MAX_DISP));
  assign res_d = err_d ? '0 : val[RES_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      err <= 1'b0;
    end else begin
      res <= res_d;
      err <= err_d;
    end
  end

  // Binary to BCD by constant division; res <= 9999 so each digit fits.
  logic [3:0][3:0] bcd;
  logic [3:0][6:0] seg_w;

  assign bcd[3] = 4'(res / 14'd1000);
  assign bcd[2] = 4'((res / 14'd100) % 14'd10);
  assign bcd[1] = 4'((res / 14'd10) % 14'd10);
  assign bcd[0] = 4'(res % 14'd10);

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_decoder u_dec (
      .digit_i (bcd[g]),
      .err_i   (err),
      .seg_o   (seg_w[g])
    );
  end

  assign seg1 = seg_w[3];
  assign seg2 = seg_w[2];
  assign seg3 = seg_w[1];
  assign seg4 = seg_w[0];

endmodule

// File: tb/tb_calc_top_module.sv
module tb_calc_top_module;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] num, a, b, n, r, num_sqrt;
  logic [3:0] op_code;
  logic [6:0] seg1, seg2, seg3, seg4;

  calc_top_module dut (
    .clk(clk), .rst_n(rst_n), .num(num), .a(a), .b(b), .n(n), .r(r),
    .num_sqrt(num_sqrt), .op_code(op_code),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          res;
    bit          err;
    logic [27:0] segs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference: plain math on wide integers, cut off once past 9999.
  function automatic exp_t model(input int op, input int nm, input int aa,
                                 input int bb, input int nn, input int rr,
                                 input int sq);
    exp_t   e;
    longint v;
    bit     bad;
    int     k, s;
    v = 0; bad = 0;
    case (op)
      0: if (nm > 7) bad = 1;
         else begin v = 1; for (int i = 2; i <= nm; i++) v = v * i; end
      1: v = aa + bb;
      2: if (aa < bb) bad = 1; else v = aa - bb;
      3: if (rr > nn) bad = 1;
         else begin
           k = (rr < nn - rr) ? rr : nn - rr;
           v = 1;
           for (int i = 1; i <= k && v <= 9999; i++) v = v * (nn - k + i) / i;
         end
      4: if (bb == 0) bad = 1; else v = aa / bb;
      5: if (bb == 0) bad = 1; else v = aa % bb;
      6: if (aa == 0) bad = 1;
         else begin s = 0; while ((longint'(1) << (s + 1)) <= aa) s++; v = s; end
      7: v = longint'(aa) * bb;
      8: if (rr > nn) bad = 1;
         else begin v = 1; for (int i = 0; i < rr && v <= 9999; i++) v = v * (nn - i); end
      9: begin v = 1; for (int i = 0; i < bb && v <= 9999 && v != 0; i++) v = v * aa; end
      10: begin s = 0; while ((s + 1) * (s + 1) <= sq) s++; v = s; end
      default: bad = 1;
    endcase
    if (v > 9999) bad = 1;
    e.err = bad;
    e.res = bad ? 0 : int'(v);
    if (bad) e.segs = {4{7'b0111111}};
    else     e.segs = {pat(e.res / 1000), pat((e.res / 100) % 10),
                       pat((e.res / 10) % 10), pat(e.res % 10)};
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic issue(input int op, input int nm, input int aa, input int bb,
                       input int nn, input int rr, input int sq);
    @(negedge clk);
    op_code = 4'(op); num = 10'(nm); a = 10'(aa); b = 10'(bb);
    n = 10'(nn); r = 10'(rr); num_sqrt = 10'(sq);
    exp_q.push_back(model(op, nm, aa, bb, nn, rr, sq));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic int rnd();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                       : int'($urandom_range(0, 24));
  endfunction

  // Monitor: one result per clock while the queue holds expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res",  int'(dut.res), e.res);
        chk("err",  int'(dut.err), int'(e.err));
        chk("segs", int'({seg1, seg2, seg3, seg4}), int'(e.segs));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    num = '0; a = '0; b = '0; n = '0; r = '0; num_sqrt = '0; op_code = '0;
    #12;
    chk("rst_res",  int'(dut.res), 0);
    chk("rst_err",  int'(dut.err), 0);
    chk("rst_segs", int'({seg1, seg2, seg3, seg4}), int'({4{7'b1000000}}));
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    // op, num, a, b, n, r, sqrt
    issue(0, 5, 0, 0, 0, 0, 0);       // 120
    issue(1, 0, 10, 5, 0, 0, 0);      // 15
    issue(2, 0, 15, 5, 0, 0, 0);      // 10
    issue(5, 0, 3, 4, 0, 0, 0);       // 3
    issue(3, 0, 0, 0, 5, 2, 0);       // 10
    issue(8, 0, 0, 0, 5, 2, 0);       // 20
    issue(4, 0, 20, 4, 0, 0, 0);      // 5
    issue(5, 0, 20, 3, 0, 0, 0);      // 2
    issue(6, 0, 16, 0, 0, 0, 0);      // 4
    issue(7, 0, 3, 4, 0, 0, 0);       // 12
    issue(9, 0, 2, 3, 0, 0, 0);       // 8
    issue(10, 0, 0, 0, 0, 0, 16);     // 4
    issue(10, 0, 0, 0, 0, 0, 17);     // 4
    // boundaries
    issue(0, 0, 0, 0, 0, 0, 0);       // 0! = 1
    issue(0, 7, 0, 0, 0, 0, 0);       // 5040
    issue(3, 0, 0, 0, 9, 0, 0);       // r=0 -> 1
    issue(3, 0, 0, 0, 9, 9, 0);       // r=n -> 1
    issue(3, 0, 0, 0, 15, 7, 0);      // 6435
    issue(3, 0, 0, 0, 16, 8, 0);      // 12870 -> err
    issue(8, 0, 0, 0, 7, 7, 0);       // 5040
    issue(9, 0, 0, 0, 0, 0, 0);       // 0^0 = 1
    issue(9, 0, 2, 13, 0, 0, 0);      // 8192
    issue(9, 0, 2, 14, 0, 0, 0);      // err
    issue(7, 0, 99, 101, 0, 0, 0);    // 9999
    issue(10, 0, 0, 0, 0, 0, 1023);   // 31
    // errors
    issue(4, 0, 7, 0, 0, 0, 0);
    issue(2, 0, 5, 9, 0, 0, 0);
    issue(0, 8, 0, 0, 0, 0, 0);
    issue(7, 0, 100, 100, 0, 0, 0);
    issue(15, 0, 0, 0, 0, 0, 0);
    drain();

    // Async reset while showing dashes: clears without a clock edge.
    mon_en = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res",  int'(dut.res), 0);
    chk("mid_rst_err",  int'(dut.err), 0);
    chk("mid_rst_segs", int'({seg1, seg2, seg3, seg4}), int'({4{7'b1000000}}));
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    for (int t = 0; t < 400; t++)
      issue(int'($urandom_range(0, 15)), $urandom_range(0, 10), rnd(), rnd(),
            rnd(), rnd(), rnd());
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
